// File: rtl/hilo_mult_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply control stage: FSM encodings,
// default multiplier latency and the MIPS funct codes the decoder maps onto this block.
package hilo_mult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_MULT_LAT = 1;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

    // Latency counter must hold MULT_LAT; a zero-latency multiplier still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned lat);
        int unsigned w;
        w = $clog2(lat + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/hilo_mult_ctrl_if.sv
// Pipeline-side bundle of the HI/LO multiply control stage: requests in,
// architectural HI/LO and status out.
interface hilo_mult_ctrl_if #(
    parameter int unsigned BIT_WIDTH = 32
);
    logic                 start;
    logic                 is_signed;
    logic [BIT_WIDTH-1:0] opA;
    logic [BIT_WIDTH-1:0] opB;
    logic                 mthi;
    logic                 mtlo;
    logic [BIT_WIDTH-1:0] wr_data;
    logic [BIT_WIDTH-1:0] hi;
    logic [BIT_WIDTH-1:0] lo;
    logic                 busy;
    logic                 done;

    modport master (
        output start, is_signed, opA, opB, mthi, mtlo, wr_data,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, is_signed, opA, opB, mthi, mtlo, wr_data,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/hilo_mult_ctrl_mult_sign_fix.sv
// Combinational sign handling around an unsigned multiplier: operand magnitudes,
// result sign, and two's-complement correction of the double-width product.
module mult_sign_fix #(
    parameter int unsigned BIT_WIDTH = 32
) (
    input  logic                   is_signed_i,
    input  logic [BIT_WIDTH-1:0]   op_a_i,
    input  logic [BIT_WIDTH-1:0]   op_b_i,
    input  logic                   neg_i,
    input  logic [2*BIT_WIDTH-1:0] prod_i,
    output logic [BIT_WIDTH-1:0]   abs_a_o,
    output logic [BIT_WIDTH-1:0]   abs_b_o,
    output logic                   neg_o,
    output logic [2*BIT_WIDTH-1:0] fixed_o
);

    // The most-negative input maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [BIT_WIDTH-1:0] magnitude(input logic sgn, input logic [BIT_WIDTH-1:0] x);
        logic [BIT_WIDTH-1:0] r;
        if (sgn && x[BIT_WIDTH-1]) begin
            r = ~x + {{(BIT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = x;
        end
        return r;
    endfunction

    assign abs_a_o = magnitude(is_signed_i, op_a_i);
    assign abs_b_o = magnitude(is_signed_i, op_b_i);
    assign neg_o   = is_signed_i & (op_a_i[BIT_WIDTH-1] ^ op_b_i[BIT_WIDTH-1]);
    assign fixed_o = neg_i ? (~prod_i + {{(2*BIT_WIDTH-1){1'b0}}, 1'b1}) : prod_i;

endmodule

// File: rtl/hilo_mult_ctrl.sv
// MULT/MULTU sequencing around an external unsigned multiplier with a fixed
// latency, plus the architectural HI/LO registers and MTHI/MTLO writes.
module hilo_mult_ctrl
    import hilo_mult_ctrl_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned MULT_LAT  = DEFAULT_MULT_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    hilo_mult_ctrl_if.slave        bus,
    output logic [BIT_WIDTH-1:0]   mul_a,
    output logic [BIT_WIDTH-1:0]   mul_b,
    input  logic [2*BIT_WIDTH-1:0] mul_p
);

    localparam int unsigned        CNT_W    = cnt_width(MULT_LAT);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [BIT_WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [2*BIT_WIDTH-1:0] prod_q, prod_d;
    logic                   neg_q, neg_d;
    logic [BIT_WIDTH-1:0]   hi_q, hi_d;
    logic [BIT_WIDTH-1:0]   lo_q, lo_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [BIT_WIDTH-1:0]   abs_a_s;
    logic [BIT_WIDTH-1:0]   abs_b_s;
    logic                   neg_s;
    logic [2*BIT_WIDTH-1:0] fixed_s;

    mult_sign_fix #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_sign_fix (
        .is_signed_i (bus.is_signed),
        .op_a_i      (bus.opA),
        .op_b_i      (bus.opB),
        .neg_i       (neg_q),
        .prod_i      (prod_q),
        .abs_a_o     (abs_a_s),
        .abs_b_o     (abs_b_s),
        .neg_o       (neg_s),
        .fixed_o     (fixed_s)
    );

    // Next-state and next-register logic for the multiply sequence and MT writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A start in the same cycle as an MT request wins; the MT write is dropped.
                if (bus.start) begin
                    mul_a_d = abs_a_s;
                    mul_b_d = abs_b_s;
                    neg_d   = neg_s;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    if (bus.mthi) begin
                        hi_d = bus.wr_data;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (bus.mtlo) begin
                        lo_d = bus.wr_data;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    prod_d  = mul_p;
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_FIX: begin
                {hi_d, lo_d} = fixed_s;
                busy_d       = 1'b0;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            mul_a_q <= {BIT_WIDTH{1'b0}};
            mul_b_q <= {BIT_WIDTH{1'b0}};
            prod_q  <= {(2*BIT_WIDTH){1'b0}};
            neg_q   <= 1'b0;
            hi_q    <= {BIT_WIDTH{1'b0}};
            lo_q    <= {BIT_WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Scoreboard bench for hilo_mult_ctrl: a latency-1 instance carries the main
// vectors; latency-0 and latency-3 instances check busy length.
module tb_hilo_mult_ctrl;

    typedef struct packed {
        logic [63:0] hilo;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ma1, mb1, ma0, mb0, ma3, mb3;
    logic [63:0] mp1, mp0, mp3, p3a, p3b;
    logic [31:0] cyc = 32'd0;
    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb[$];
    logic        prev_done1 = 1'b0;

    always #5 clk = ~clk;

    hilo_mult_ctrl_if #(.BIT_WIDTH(32)) b1 ();
    hilo_mult_ctrl_if #(.BIT_WIDTH(32)) b0 ();
    hilo_mult_ctrl_if #(.BIT_WIDTH(32)) b3 ();

    hilo_mult_ctrl #(.BIT_WIDTH(32), .MULT_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave), .mul_a(ma1), .mul_b(mb1), .mul_p(mp1));
    hilo_mult_ctrl #(.BIT_WIDTH(32), .MULT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave), .mul_a(ma0), .mul_b(mb0), .mul_p(mp0));
    hilo_mult_ctrl #(.BIT_WIDTH(32), .MULT_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave), .mul_a(ma3), .mul_b(mb3), .mul_p(mp3));

    // Bench multipliers: combinational, one-edge and three-edge delayed.
    assign mp0 = {32'd0, ma0} * {32'd0, mb0};
    always_ff @(posedge clk) begin
        mp1 <= {32'd0, ma1} * {32'd0, mb1};
        p3a <= {32'd0, ma3} * {32'd0, mb3};
        p3b <= p3a;
        mp3 <= p3b;
    end

    always_ff @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse of the latency-1 instance is matched against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (b1.done === 1'b1) begin
            check("done_single_cycle", {63'd0, prev_done1}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("hilo", {b1.hi, b1.lo}, e.hilo);
                check("latency", {32'd0, cyc - e.cyc}, 64'd3);
            end
        end
        prev_done1 = b1.done;
    end

    task automatic mul_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ea, input logic [31:0] eb,
                          input logic [63:0] ep, input logic poke);
        exp_t e;
        @(negedge clk);
        b1.start = 1'b1; b1.is_signed = sgn; b1.opA = a; b1.opB = b;
        @(negedge clk);
        b1.start = 1'b0;
        e.hilo = ep;
        e.cyc  = cyc;
        sb.push_back(e);
        check("mul_a", {32'd0, ma1}, {32'd0, ea});
        check("mul_b", {32'd0, mb1}, {32'd0, eb});
        if (poke) begin
            b1.start = 1'b1; b1.is_signed = 1'b0; b1.opA = 32'd9; b1.opB = 32'd9;
            b1.mthi = 1'b1; b1.wr_data = 32'h12345678;
            @(negedge clk);
            b1.start = 1'b0; b1.mthi = 1'b0;
            check("mul_a_hold", {32'd0, ma1}, {32'd0, ea});
        end
        for (int i = 0; i < 20 && b1.busy; i++) @(negedge clk);
        check("busy_clears", {63'd0, b1.busy}, 64'd0);
    endtask

    function automatic logic busy_of(input int sel);
        if (sel == 0) return b0.busy;
        else return b3.busy;
    endfunction

    task automatic busy_len(input int sel, output int n);
        @(negedge clk);
        if (sel == 0) begin
            b0.start = 1'b1; b0.is_signed = 1'b0; b0.opA = 32'd6; b0.opB = 32'd7;
        end else begin
            b3.start = 1'b1; b3.is_signed = 1'b0; b3.opA = 32'd6; b3.opB = 32'd7;
        end
        @(negedge clk);
        b0.start = 1'b0; b3.start = 1'b0;
        n = 0;
        while (busy_of(sel) && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        rst = 1'b0;
        b1.start = 1'b0; b1.is_signed = 1'b0; b1.opA = 32'd0; b1.opB = 32'd0;
        b1.mthi = 1'b0; b1.mtlo = 1'b0; b1.wr_data = 32'd0;
        b0.start = 1'b0; b0.is_signed = 1'b0; b0.opA = 32'd0; b0.opB = 32'd0;
        b0.mthi = 1'b0; b0.mtlo = 1'b0; b0.wr_data = 32'd0;
        b3.start = 1'b0; b3.is_signed = 1'b0; b3.opA = 32'd0; b3.opB = 32'd0;
        b3.mthi = 1'b0; b3.mtlo = 1'b0; b3.wr_data = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_hilo", {b1.hi, b1.lo}, 64'd0);
        check("rst_mul_ab", {ma1, mb1}, 64'd0);
        check("rst_busy_done", {62'd0, b1.busy, b1.done}, 64'd0);
        rst = 1'b1;

        mul_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
        mul_op(1'b1, 32'hFFFFFFFD, 32'd5, 32'd3, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0);
        mul_op(1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
        mul_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1, 64'h00000000_00000001, 1'b0);
        mul_op(1'b1, 32'd0, 32'hFFFFFFF9, 32'd0, 32'd7, 64'd0, 1'b0);
        mul_op(1'b0, 32'd2, 32'd3, 32'd2, 32'd3, 64'd6, 1'b1);

        @(negedge clk);
        b1.mthi = 1'b1; b1.mtlo = 1'b1; b1.wr_data = 32'hA5A5A5A5;
        @(negedge clk);
        b1.mthi = 1'b0; b1.mtlo = 1'b0;
        check("mt_both", {b1.hi, b1.lo}, 64'hA5A5A5A5_A5A5A5A5);
        check("mt_no_done", {63'd0, b1.done}, 64'd0);

        @(negedge clk);
        b1.start = 1'b1; b1.is_signed = 1'b0; b1.opA = 32'd9; b1.opB = 32'd9;
        @(negedge clk);
        b1.start = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_async_busy", {63'd0, b1.busy}, 64'd0);
        check("rst_async_hilo", {b1.hi, b1.lo}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mul_op(1'b0, 32'd6, 32'd7, 32'd6, 32'd7, 64'd42, 1'b0);

        busy_len(0, n);
        check("busy_len_lat0", 64'(n), 64'd2);
        check("lat0_hilo", {b0.hi, b0.lo}, 64'd42);
        busy_len(3, n);
        check("busy_len_lat3", 64'(n), 64'd5);
        check("lat3_hilo", {b3.hi, b3.lo}, 64'd42);

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hilo_mult_ctrl.md
Name: hilo_mult_ctrl

Overview:
Control and result stage wrapped around the team's unsigned multiplier. It takes MIPS MULT/MULTU requests and conditions the operands, which are absolute values for signed ops. It drives the multiplier, waits a fixed latency, sign-corrects the 2*BIT_WIDTH product, and writes the architectural HI/LO registers. It also services MTHI/MTLO and exposes busy so the pipeline can stall MFHI/MFLO.

Parameters:
BIT_WIDTH, 32, operand width; HI/LO are each BIT_WIDTH.
MULT_LAT, 1, edges from mul_a/mul_b changing to mul_p being valid. 0 means a combinational multiplier.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  begin multiply; sampled only in IDLE
is_signed  in  1  1=MULT, 0=MULTU; sampled with start
opA  in  BIT_WIDTH  multiplicand
opB  in  BIT_WIDTH  multiplier
mthi  in  1  write wr_data to HI
mtlo  in  1  write wr_data to LO
wr_data  in  BIT_WIDTH  MTHI/MTLO data
mul_a  out  BIT_WIDTH  registered operand to multiplier
mul_b  out  BIT_WIDTH  registered operand to multiplier
mul_p  in  2*BIT_WIDTH  unsigned product from multiplier
hi  out  BIT_WIDTH  HI register
lo  out  BIT_WIDTH  LO register
busy  out  1  multiply in flight; HI/LO not yet valid
done  out  1  one-cycle pulse, HI/LO just updated by a multiply

Behaviour:
- Reset (rst=0, async): state=IDLE. Set hi, lo, mul_a, mul_b, counter, product reg and neg flag to 0. Set busy=0 and done=0.
- States: IDLE, WAIT, FIX. All outputs are registered.
- IDLE, start=1 at edge E0:
  - If is_signed=1, load mul_a=|opA| and mul_b=|opB|; otherwise load raw operands.
  - neg = is_signed & (opA[MSB] ^ opB[MSB]).
  - counter = MULT_LAT. Go to WAIT. busy=1.
- |x| of the most-negative value (0x80000000) is 0x80000000 as an unsigned value; no overflow.
- WAIT: if counter==0, capture mul_p into the product reg and go to FIX. Otherwise decrement the counter. With MULT_LAT=L, capture happens at edge E(1+L).
- FIX, at edge E(2+L):
  - {hi,lo} = neg ? (~p + 1) mod 2^(2*BIT_WIDTH) : p.
  - busy=0, done=1 for exactly one cycle. Go to IDLE.
- Latency: HI/LO are valid L+2 edges after start is sampled. busy is high for exactly L+2 cycles.
- mul_a/mul_b hold their values until the next accepted start.
- start while busy: ignored, with no queueing and no state change.
- mthi/mtlo while busy: ignored.
- In IDLE, mthi and/or mtlo write hi/lo at the next edge. Both asserted together write both. done is not asserted.
- start together with mthi/mtlo in IDLE: start is accepted and the MT write is dropped.
- Reset mid-operation: immediate return to the reset state. The in-flight result is discarded and no done pulse is issued.
- Arithmetic: the unsigned product of two |operands| always fits in 2*BIT_WIDTH. Negation wraps in 2*BIT_WIDTH, so a zero product stays zero when neg=1.
- Counter width: clog2(MULT_LAT+1), minimum 1 bit.

Decomposition:
- Shared package/header:
  - state encodings IDLE/WAIT/FIX
  - default MULT_LAT
  - MIPS funct codes MULT/MULTU/MTHI/MTLO, used by the decoder that drives this block
- One natural sub-module: mult_sign_fix, purely combinational. Its jobs are operand abs, the neg flag, and 2*BIT_WIDTH conditional negate.
- The FSM, counter and HI/LO registers stay in hilo_mult_ctrl.
- The multiplier is external and connects via mul_a/mul_b/mul_p.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, MULT_LAT=1, bench multiplier delayed one edge:
  - mul_a = mul_b = 0xFFFFFFFF
  - HI=0xFFFFFFFE, LO=0x00000001 exactly 3 edges after start
  - done is a single-cycle pulse
- MULT -3*5:
  - mul_a=3, mul_b=5
  - HI=0xFFFFFFFF, LO=0xFFFFFFF1
- MULT 0x80000000*0x80000000 → HI=0x40000000, LO=0x00000000.
- MULT -1*-1 → HI=0, LO=1.
- MULT 0*-7 → HI=0, LO=0.
- MULT_LAT=0 and MULT_LAT=3 → busy high for exactly 2 and 5 cycles respectively.
- Second start asserted during busy: ignored, HI/LO reflect the first operands only.
- mthi with wr_data=0x12345678 while busy: ignored.
- In IDLE, mthi+mtlo with wr_data=0xA5A5A5A5 → both registers = 0xA5A5A5A5, done stays 0.
- rst asserted in WAIT:
  - busy, hi and lo go to 0 without waiting for a clock edge
  - no done pulse
  - a subsequent MULTU 6*7 yields HI=0, LO=42
